i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 166 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-client round-robin arbiter in front of a single I2C master
//
// Purpose:
//   Shares one byte-level I2C master between two clients. A client raises req
//   and holds it until its done pulse. The arbiter grants one client, launches
//   the master with a single go pulse, tracks the master's idle level through
//   busy and complete, collects NACK/timeout into one error flag and reports it
//   with a one-cycle done/err pulse to the owning client.
//
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   req*/rw*/nbyte*/dev*/ptr*/wdat*   per-client transaction request and fields
//   gnt*, rdy*, done*, err*  per-client grant, gated ready, completion, error
//   rdat                     master read data, shared by both clients
//   go, rw, N_Byte, dev_add, R_Pointer, dwr   launch pulse and muxed fields to the master
//   ready, done, drd, ack_e  master byte strobe, idle level, read data, NACK flag

module i2c_arbiter #(
  parameter int TIMEOUT = 20000,
  parameter int TW      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [5:0] nbyte0,
  input  logic [5:0] nbyte1,
  input  logic [6:0] dev0,
  input  logic [6:0] dev1,
  input  logic [7:0] ptr0,
  input  logic [7:0] ptr1,
  input  logic [7:0] wdat0,
  input  logic [7:0] wdat1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rdy0,
  output logic       rdy1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdat,
  output logic       go,
  output logic       rw,
  output logic [5:0] N_Byte,
  output logic [6:0] dev_add,
  output logic [7:0] R_Pointer,
  output logic [7:0] dwr,
  input  logic       ready,
  input  logic       done,
  input  logic [7:0] drd,
  input  logic       ack_e
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] RELEASE   = 3'd4;

  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic          owner;     // 0 = client 0, 1 = client 1
  logic          last;      // client served by the previous transaction
  logic          err_flag;
  logic          go_q;
  logic [TW-1:0] cnt;

  logic          held;
  logic          pick;
  logic          timeout_hit;
  logic          rel;

  // Grant is held from LAUNCH until RELEASE; RELEASE itself drops it.
  assign held        = (state == LAUNCH) || (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign rel         = (state == RELEASE);
  assign timeout_hit = (cnt == CNT_MAX);

  // Round-robin: on contention the client that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last;
    else              pick = req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;     // makes client 0 the first contention winner
      err_flag <= 1'b0;
      cnt      <= '0;
      go_q     <= 1'b0;
    end else begin
      // go is registered off LAUNCH, so it appears one cycle after the grant.
      go_q <= (state == LAUNCH);
      case (state)
        IDLE: begin
          if (done && (req0 || req1)) begin
            owner <= pick;
            state <= LAUNCH;
          end
        end
        LAUNCH: begin
          err_flag <= 1'b0;
          cnt      <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (!timeout_hit) cnt <= cnt + 1'b1;
          if (timeout_hit) begin
            err_flag <= 1'b1;
            state    <= RELEASE;
          end else begin
            if (ack_e) err_flag <= 1'b1;
            if ((state == WAIT_BUSY) && !done)     state <= WAIT_DONE;
            else if ((state == WAIT_DONE) && done) state <= RELEASE;
          end
        end
        RELEASE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt0  = held & ~owner;
  assign gnt1  = held &  owner;
  assign rdy0  = gnt0 & ready;
  assign rdy1  = gnt1 & ready;
  assign done0 = rel & ~owner;
  assign done1 = rel &  owner;
  assign err0  = done0 & err_flag;
  assign err1  = done1 & err_flag;
  assign go    = go_q;
  assign rdat  = drd;

  always_comb begin
    rw        = 1'b0;
    N_Byte    = '0;
    dev_add   = '0;
    R_Pointer = '0;
    dwr       = '0;
    if (held) begin
      if (owner) begin
        rw        = rw1;
        N_Byte    = nbyte1;
        dev_add   = dev1;
        R_Pointer = ptr1;
        dwr       = wdat1;
      end else begin
        rw        = rw0;
        N_Byte    = nbyte0;
        dev_add   = dev0;
        R_Pointer = ptr0;
        dwr       = wdat0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - directed self-checking bench for i2c_arbiter

module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, rw0, rw1;
  logic [5:0] nbyte0, nbyte1;
  logic [6:0] dev0, dev1;
  logic [7:0] ptr0, ptr1, wdat0, wdat1;
  logic       gnt0, gnt1, rdy0, rdy1, done0, done1, err0, err1;
  logic [7:0] rdat;
  logic       go, rw;
  logic [5:0] N_Byte;
  logic [6:0] dev_add;
  logic [7:0] R_Pointer, dwr;
  logic       ready, done, ack_e;
  logic [7:0] drd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [46:0] outs;
  assign outs = {gnt0, gnt1, rdy0, rdy1, done0, done1, err0, err1, go, rw,
                 N_Byte, dev_add, R_Pointer, dwr, rdat};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_arbiter #(.TIMEOUT(20), .TW(15)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .nbyte0(nbyte0), .nbyte1(nbyte1), .dev0(dev0), .dev1(dev1),
    .ptr0(ptr0), .ptr1(ptr1), .wdat0(wdat0), .wdat1(wdat1),
    .gnt0(gnt0), .gnt1(gnt1), .rdy0(rdy0), .rdy1(rdy1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdat(rdat), .go(go), .rw(rw), .N_Byte(N_Byte), .dev_add(dev_add),
    .R_Pointer(R_Pointer), .dwr(dwr),
    .ready(ready), .done(done), .drd(drd), .ack_e(ack_e)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(output int c, output logic which);
    c = -1;
    which = 1'b0;
    for (int i = 0; i < 30 && c < 0; i++) begin
      @(negedge clk); #1;
      if (gnt0 | gnt1) begin
        c = cyc;
        which = gnt1;
      end
    end
    if (c < 0) check("gnt_wait_expired", 64'd0, 64'd1);
  endtask

  task automatic wait_go(output int c);
    c = -1;
    for (int i = 0; i < 30 && c < 0; i++) begin
      @(negedge clk); #1;
      if (go) c = cyc;
    end
    if (c < 0) check("go_wait_expired", 64'd0, 64'd1);
  endtask

  // Master behaviour after go: done low for 'hold' cycles, optional NACK and
  // ready/read-data strobes at given cycle offsets, then done returns high.
  task automatic master_run(input int hold, input int ack_at, input int rdy_at, output int rise);
    done = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      ack_e = (i == ack_at);
      ready = (i == rdy_at);
      drd   = (i == rdy_at) ? 8'hA5 : 8'h00;
      #1;
      if (i == 1) check("go_one_cycle", 64'(go), 64'd0);
      if (i == rdy_at) begin
        check("rdy_owner", 64'(rdy1), 64'd1);
        check("rdy_other", 64'(rdy0), 64'd0);
        check("rdat_route", 64'(rdat), 64'hA5);
      end
    end
    @(negedge clk);
    ack_e = 1'b0;
    ready = 1'b0;
    drd   = 8'h00;
    #1;
    check("no_early_done", 64'(done0 | done1), 64'd0);
    done = 1'b1;
    rise = cyc;
  endtask

  task automatic wait_done(output int c, output logic which, output logic [1:0] e);
    c = -1;
    which = 1'b0;
    e = 2'b00;
    for (int i = 0; i < 40 && c < 0; i++) begin
      @(negedge clk); #1;
      if (done0 | done1) begin
        c = cyc;
        which = done1;
        e = {err1, err0};
        check("gnt_dropped", 64'(gnt0 | gnt1), 64'd0);
      end
    end
    if (c < 0) check("done_wait_expired", 64'd0, 64'd1);
  endtask

  int         cg, cgo, rise, cd, cd0;
  logic       w;
  logic [1:0] e;

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    nbyte0 = 6'd2; nbyte1 = 6'd3; dev0 = 7'h48; dev1 = 7'h33;
    ptr0 = 8'h01; ptr1 = 8'h22; wdat0 = 8'h3C; wdat1 = 8'h5A;
    ready = 0; done = 1; drd = 8'h00; ack_e = 0;

    repeat (3) @(negedge clk);
    #1 check("reset_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    @(negedge clk); #1 check("idle_outs", 64'(outs), 64'd0);

    // Master busy in IDLE: no grant while done is low.
    done = 1'b0;
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 check("idle_busy_nogrant", 64'(gnt0 | gnt1), 64'd0);
    end
    done = 1'b1;

    // Single write from client 0.
    wait_gnt(cg, w);
    check("wr_owner", 64'(w), 64'd0);
    check("wr_dev_add", 64'(dev_add), 64'h48);
    check("wr_nbyte", 64'(N_Byte), 64'd2);
    check("wr_rw", 64'(rw), 64'd0);
    check("wr_ptr", 64'(R_Pointer), 64'h01);
    check("wr_dwr", 64'(dwr), 64'h3C);
    check("wr_go_not_yet", 64'(go), 64'd0);
    wait_go(cgo);
    check("gnt_to_go", 64'(cgo - cg), 64'd1);
    check("wr_gnt_at_go", 64'(gnt0), 64'd1);
    master_run(10, 0, 0, rise);
    wait_done(cd, w, e);
    check("wr_done_lat", 64'(cd - rise), 64'd1);
    check("wr_done_who", 64'(w), 64'd0);
    check("wr_err", 64'(e), 64'd0);
    req0 = 1'b0;
    @(negedge clk); #1 check("done_one_cycle", 64'(done0), 64'd0);

    // Contention from reset: 0 first, then 1, then 0 again.
    reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    dev0 = 7'h10; dev1 = 7'h20;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(cg, w);
    check("cont_first", 64'(w), 64'd0);
    wait_go(cgo);
    master_run(5, 0, 0, rise);
    wait_done(cd0, w, e);
    check("cont_done0", 64'(w), 64'd0);
    req0 = 1'b0;
    wait_go(cgo);
    check("done0_to_go1", 64'(cgo - cd0), 64'd3);
    check("cont_gnt1", 64'(gnt1), 64'd1);
    check("cont_dev1", 64'(dev_add), 64'h20);
    master_run(4, 0, 0, rise);
    wait_done(cd, w, e);
    check("cont_done1", 64'(w), 64'd1);
    req1 = 1'b0;
    @(negedge clk); #1;
    req0 = 1'b1; req1 = 1'b1;
    wait_gnt(cg, w);
    check("cont_alternate", 64'(w), 64'd0);
    wait_go(cgo);
    master_run(3, 0, 0, rise);
    wait_done(cd, w, e);
    check("cont_done_alt", 64'(w), 64'd0);
    req0 = 1'b0; req1 = 1'b0;

    // Client 1 read with a ready/read-data strobe.
    rw1 = 1'b1; nbyte1 = 6'd4; dev1 = 7'h50; ptr1 = 8'h10;
    req1 = 1'b1;
    wait_gnt(cg, w);
    check("rd_owner", 64'(w), 64'd1);
    check("rd_rw", 64'(rw), 64'd1);
    check("rd_nbyte", 64'(N_Byte), 64'd4);
    wait_go(cgo);
    master_run(8, 0, 4, rise);
    wait_done(cd, w, e);
    check("rd_done_who", 64'(w), 64'd1);
    check("rd_err", 64'(e), 64'd0);
    req1 = 1'b0;

    // NACK during WAIT_DONE on a client 1 read.
    req1 = 1'b1;
    wait_gnt(cg, w);
    wait_go(cgo);
    master_run(8, 3, 0, rise);
    wait_done(cd, w, e);
    check("nack_lat", 64'(cd - rise), 64'd1);
    check("nack_who", 64'(w), 64'd1);
    check("nack_err", 64'(e), 64'h2);
    req1 = 1'b0;

    // Timeout stuck in WAIT_BUSY: master never lowers done.
    req0 = 1'b1;
    wait_gnt(cg, w);
    wait_go(cgo);
    wait_done(cd, w, e);
    check("to_busy_cycles", 64'(cd - cgo), 64'd20);
    check("to_busy_who", 64'(w), 64'd0);
    check("to_busy_err", 64'(e), 64'h1);
    req0 = 1'b0;

    // Timeout stuck in WAIT_DONE: master never returns done.
    req1 = 1'b1;
    wait_gnt(cg, w);
    wait_go(cgo);
    done = 1'b0;
    wait_done(cd, w, e);
    check("to_done_cycles", 64'(cd - cgo), 64'd20);
    check("to_done_err", 64'(e), 64'h2);
    req1 = 1'b0;
    done = 1'b1;

    // Reset during WAIT_DONE, then a normal grant to client 1.
    req1 = 1'b1;
    wait_gnt(cg, w);
    wait_go(cgo);
    done = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("pre_reset_gnt", 64'(gnt1), 64'd1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_outs", 64'(outs), 64'd0);
    reset = 1'b0;
    done = 1'b1;
    wait_gnt(cg, w);
    check("midrst_no_done", 64'(done0 | done1), 64'd0);
    check("midrst_regrant", 64'(w), 64'd1);
    wait_go(cgo);
    master_run(4, 0, 0, rise);
    wait_done(cd, w, e);
    check("midrst_done_who", 64'(w), 64'd1);
    check("midrst_err", 64'(e), 64'd0);
    req1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
